// File: rtl/ahb_sram_pkg.sv
// rtl/ahb_sram_pkg.sv - shared encodings, response FSM states and lane-mask helper for the AHB SRAM bridge
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        RS_OK,
        RS_STALL,
        RS_ERR1,
        RS_ERR2
    } resp_state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] mask;
    } lane_sel_t;

    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    // Oversized or misaligned transfers are flagged illegal; their mask is never used.
    function automatic lane_sel_t byte_mask(input logic [2:0] size, input logic [1:0] addr);
        lane_sel_t r;
        r.illegal = 1'b0;
        r.mask    = 4'b0000;
        case (size)
            HSIZE_BYTE: r.mask = 4'b0001 << addr;
            HSIZE_HALF: begin
                r.mask    = addr[1] ? 4'b1100 : 4'b0011;
                r.illegal = addr[0];
            end
            HSIZE_WORD: begin
                r.mask    = 4'b1111;
                r.illegal = |addr;
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// rtl/ahb_sram_wbuf.sv - one-entry posted write buffer with read-data byte merge
module ahb_sram_wbuf
    import ahb_sram_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [3:0]    load_mask_i,
    input  logic [DW-1:0] load_data_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] sram_q_i,
    output logic          wb_valid_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [3:0]    wb_mask_o,
    output logic [DW-1:0] wb_data_o,
    output logic [DW-1:0] rd_data_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [3:0]    mask_q,  mask_d;
    logic [DW-1:0] data_q,  data_d;
    logic          hit;

    // A reload in the same cycle as a drain keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = load_addr_i;
            mask_d  = load_mask_i;
            data_d  = load_data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    assign hit = valid_q && (addr_q == rd_addr_i);

    always_comb begin
        rd_data_o = sram_q_i;
        for (int b = 0; b < 4; b++) begin
            if (hit && mask_q[b]) begin
                rd_data_o[8*b +: 8] = data_q[8*b +: 8];
            end
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_addr_o  = addr_q;
    assign wb_mask_o  = mask_q;
    assign wb_data_o  = data_q;

endmodule

// File: rtl/ahb_sram_bridge.sv
// rtl/ahb_sram_bridge.sv - AHB-lite slave to single-port byte-enabled SRAM bridge with posted writes
module ahb_sram_bridge
    import ahb_sram_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          HSEL,
    input  logic [AW+1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA,
    output logic          SRAM_CEN,
    output logic          SRAM_GWEN,
    output logic [3:0]    SRAM_BEN,
    output logic [AW-1:0] SRAM_A,
    output logic [DW-1:0] SRAM_D,
    input  logic [DW-1:0] SRAM_Q
);

    resp_state_e   state_q, state_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic          dp_err_q,   dp_err_d;
    logic [AW-1:0] dp_addr_q,  dp_addr_d;
    logic [3:0]    dp_mask_q,  dp_mask_d;

    lane_sel_t     lane;
    logic          trans_act, fsm_open, dp_wr_ok, collision;
    logic          accept, rd_issue, wr_issue, wb_load;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_mask;
    logic [DW-1:0] wb_data, merged_rdata;
    logic          hreadyout_c, hresp_c;

    assign lane      = byte_mask(HSIZE, HADDR[1:0]);
    assign trans_act = HSEL & htrans_active(HTRANS);
    // The stall cycle's follow-up (STALL) completes the held write with HREADYOUT=1, so it may accept.
    assign fsm_open  = (state_q == RS_OK) || (state_q == RS_STALL);
    assign dp_wr_ok  = dp_valid_q & dp_write_q & ~dp_err_q;
    // Collision ignores HREADY: during our own data phase HREADY is our HREADYOUT.
    assign collision = RSTN & (state_q == RS_OK) & dp_wr_ok & wb_valid
                     & trans_act & ~HWRITE & ~lane.illegal;
    assign accept    = RSTN & trans_act & HREADY & fsm_open & ~collision;
    assign rd_issue  = accept & ~HWRITE & ~lane.illegal;
    assign wr_issue  = RSTN & wb_valid & ~rd_issue;
    assign wb_load   = dp_wr_ok & HREADY & ~collision;

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_err_d   = dp_err_q;
        dp_addr_d  = dp_addr_q;
        dp_mask_d  = dp_mask_q;
        if (HREADY) begin
            dp_valid_d = accept;
            dp_write_d = accept & HWRITE;
            dp_err_d   = accept & lane.illegal;
            dp_addr_d  = accept ? HADDR[AW+1:2] : '0;
            dp_mask_d  = accept ? lane.mask : 4'b0000;
        end
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_c = 1'b1;
        hresp_c     = 1'b0;
        case (state_q)
            RS_OK: begin
                if (collision) begin
                    hreadyout_c = 1'b0;
                    state_d     = RS_STALL;
                end else if (accept && lane.illegal) begin
                    state_d = RS_ERR1;
                end
            end
            RS_STALL: state_d = (accept && lane.illegal) ? RS_ERR1 : RS_OK;
            RS_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 1'b1;
                state_d     = RS_ERR2;
            end
            RS_ERR2: begin
                hresp_c = 1'b1;
                state_d = RS_OK;
            end
            default: state_d = RS_OK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= RS_OK;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_err_q   <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= '0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_err_q   <= dp_err_d;
            dp_addr_q  <= dp_addr_d;
            dp_mask_q  <= dp_mask_d;
        end
    end

    ahb_sram_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk_i       (CLK),
        .rstn_i      (RSTN),
        .load_i      (wb_load),
        .drain_i     (wr_issue),
        .load_addr_i (dp_addr_q),
        .load_mask_i (dp_mask_q),
        .load_data_i (HWDATA),
        .rd_addr_i   (dp_addr_q),
        .sram_q_i    (SRAM_Q),
        .wb_valid_o  (wb_valid),
        .wb_addr_o   (wb_addr),
        .wb_mask_o   (wb_mask),
        .wb_data_o   (wb_data),
        .rd_data_o   (merged_rdata)
    );

    // Outputs are forced idle while RSTN is low so a pending entry never reaches the macro.
    assign HREADYOUT = RSTN ? hreadyout_c : 1'b1;
    assign HRESP     = RSTN & hresp_c;
    assign HRDATA    = (RSTN & dp_valid_q & ~dp_write_q & ~dp_err_q) ? merged_rdata : '0;
    assign SRAM_CEN  = ~(rd_issue | wr_issue);
    assign SRAM_GWEN = ~wr_issue;
    assign SRAM_BEN  = wr_issue ? ~wb_mask : 4'hF;
    assign SRAM_A    = rd_issue ? HADDR[AW+1:2] : (wr_issue ? wb_addr : '0);
    assign SRAM_D    = wr_issue ? wb_data : '0;

endmodule
